rca_operand_sequencer: RTL

// - Sequential upstream/downstream wrapper for a combinational W-bit ripple-carry adder netlist.
// - Collects two operand words from a valid/ready stream and drives them on add_a/add_b.
// - Waits a fixed settle time for the deep ripple path, then captures the W+1-bit add_sum.
// - Presents the captured sum on a valid/ready output stream.

---
 rtl/rca_operand_sequencer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/rca_operand_sequencer.sv
// Operand sequencer around a combinational ripple-carry adder: collects A/B, waits SETTLE cycles, captures the sum.
// Optional sum checker enabled by defining RCA_SUM_CHECK_EN (adds chk_err and err_count ports).
module rca_operand_sequencer #(
    parameter int W      = 16,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic [W-1:0]     add_a,
    output logic [W-1:0]     add_b,
    input  logic [W:0]       add_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W:0]       out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
`ifdef RCA_SUM_CHECK_EN
    ,
    output logic             chk_err,
    output logic [CNT_W-1:0] err_count
`endif
);

    typedef enum logic [1:0] {
        ST_GET_A,
        ST_GET_B,
        ST_SETTLE,
        ST_OUT
    } state_t;

    localparam logic [7:0] SETTLE_LD = 8'(SETTLE);

    state_t       state;
    logic [W-1:0] a_reg;
    logic [7:0]   wait_cnt;

`ifdef RCA_SUM_CHECK_EN
    logic [W:0] sum_ref;

    always_comb begin
        sum_ref = {1'b0, add_a} + {1'b0, add_b};
    end
`endif

    // add_a/add_b are only written on a B transfer so the adder inputs stay quiet while settling.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_GET_A;
            a_reg     <= '0;
            add_a     <= '0;
            add_b     <= '0;
            wait_cnt  <= '0;
            out_sum   <= '0;
            out_valid <= 1'b0;
            out_count <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
`ifdef RCA_SUM_CHECK_EN
            chk_err   <= 1'b0;
            err_count <= '0;
`endif
        end else begin
            case (state)
                ST_GET_A: begin
                    if (in_valid) begin
                        a_reg <= in_data;
                        state <= ST_GET_B;
                        busy  <= 1'b1;
                    end
                end
                ST_GET_B: begin
                    if (in_valid) begin
                        add_a    <= a_reg;
                        add_b    <= in_data;
                        wait_cnt <= SETTLE_LD;
                        state    <= ST_SETTLE;
                        in_ready <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (wait_cnt != 8'd0) begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end else begin
                        out_sum   <= add_sum;
                        out_valid <= 1'b1;
                        state     <= ST_OUT;
`ifdef RCA_SUM_CHECK_EN
                        if (add_sum != sum_ref) begin
                            chk_err <= 1'b1;
                            if (err_count != '1) begin
                                err_count <= err_count + CNT_W'(1);
                            end
                        end
`endif
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_count <= out_count + CNT_W'(1);
                        state     <= ST_GET_A;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_GET_A;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
